// File: rtl/decoder_pkg.sv
// Shared decode helpers for the small select-to-strobe decoders.
// dec2to4 is the single definition of the 2-to-4 decode; any unknown on the
// enable or select resolves to "nothing selected" so a strobe is never
// driven from an undefined select.
package decoder_pkg;

   localparam int DEC_W = 4;
   localparam int SEL_W = 2;

   typedef logic [DEC_W-1:0] dec_onehot_t;

   // Active-low enable; sel[1] is the MSB. Case items never match X/Z,
   // so unknown inputs fall through to the all-zero default.
   function automatic dec_onehot_t dec2to4(input logic en_n,
                                           input logic [SEL_W-1:0] sel);
      dec_onehot_t d;
      d = '0;
      case (en_n)
         1'b0: begin
            case (sel)
               2'b00:   d = 4'b0001;
               2'b01:   d = 4'b0010;
               2'b10:   d = 4'b0100;
               2'b11:   d = 4'b1000;
               default: d = '0;
            endcase
         end
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decoder24_assign.sv
// 2-to-4 line decoder with active-low enable and an optional registered,
// optionally inverted one-hot output. Port order keeps en/a/b/y first so
// older positional instantiations that omit clk/rst_n still bind.
module decoder24_assign
   import decoder_pkg::*;
#(
   parameter bit REGISTERED     = 1'b1,
   parameter bit OUT_ACTIVE_LOW = 1'b0
) (
   input  logic             en,
   input  logic             a,
   input  logic             b,
   output logic [DEC_W-1:0] y,
   input  logic             clk,
   input  logic             rst_n
);

   // Idle output word; also the XOR mask that applies output polarity.
   localparam dec_onehot_t IDLE = {DEC_W{OUT_ACTIVE_LOW}};

   dec_onehot_t d_p0;

   // Stage 0: combinational decode of the live inputs.
   always_comb begin
      d_p0 = dec2to4(en, {a, b});
   end

   // Decode never produces more than one active line.
   always_comb begin
      assert ($onehot0(d_p0));
   end

   generate
      if (REGISTERED) begin : g_reg
         // Stage 1: output register, forced idle asynchronously by reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y <= IDLE;
            end else begin
               y <= d_p0 ^ IDLE;
            end
         end

         a_reset_idle : assert property (@(posedge clk) !rst_n |-> (y == IDLE));
      end else begin : g_comb
         assign y = d_p0 ^ IDLE;
      end
   endgenerate

endmodule

// File: tb/tb_decoder24_assign.sv
// Directed and random bench for decoder24_assign: one registered
// active-high instance and one combinational active-low instance share the
// same inputs and are checked against a behavioural reference.
module tb_decoder24_assign;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       a;
   logic       b;
   logic [3:0] y_reg;
   logic [3:0] y_cmb;

   int checks;
   int failures;

   bit         cmp_on;
   bit         have;
   logic [3:0] last_dec;

   decoder24_assign #(.REGISTERED(1'b1), .OUT_ACTIVE_LOW(1'b0)) u_reg (
      .en(en), .a(a), .b(b), .y(y_reg), .clk(clk), .rst_n(rst_n)
   );

   decoder24_assign #(.REGISTERED(1'b0), .OUT_ACTIVE_LOW(1'b1)) u_cmb (
      .en(en), .a(a), .b(b), .y(y_cmb), .clk(clk), .rst_n(rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode: line number is 2*a+b, nothing selected unless en is
   // a clean 0 and the select is fully known.
   function automatic logic [3:0] model(input logic e, input logic sa, input logic sb);
      int idx;
      if (e !== 1'b0 || $isunknown({sa, sb})) return 4'b0000;
      idx = (sa ? 2 : 0) + (sb ? 1 : 0);
      return 4'(1 << idx);
   endfunction

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Remember what each rising edge outside reset should have captured.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         last_dec = model(en, a, b);
         have     = 1'b1;
      end
   end

   always @(negedge rst_n) have = 1'b0;

   // Per-cycle comparison of both instances against the reference.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("reg_model", y_reg, (rst_n === 1'b1 && have) ? last_dec : 4'b0000);
         check("cmb_model", y_cmb, ~model(en, a, b));
         checks++;
         if (!$onehot0(y_reg) || $isunknown(y_reg)) begin
            failures++;
            $display("FAIL reg_onehot0: got %b expected one-hot or zero", y_reg);
         end
      end
   end

   // Wait for a rising edge, then move inputs away from it.
   task automatic drive(input logic e, input logic sa, input logic sb);
      @(posedge clk);
      #2;
      en = e;
      a  = sa;
      b  = sb;
   endtask

   initial begin
      logic [3:0] tt [4];
      logic [3:0] exp;
      tt[0] = 4'b0001;
      tt[1] = 4'b0010;
      tt[2] = 4'b0100;
      tt[3] = 4'b1000;

      checks   = 0;
      failures = 0;
      cmp_on   = 1'b0;
      have     = 1'b0;
      last_dec = 4'b0000;
      rst_n    = 1'b0;
      en       = 1'b1;
      a        = 1'b0;
      b        = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_idle", y_reg, 4'b0000);
      #2;
      rst_n  = 1'b1;
      cmp_on = 1'b1;

      // Reset asserted mid-cycle clears a selected line without a clock.
      drive(1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("pre_reset_sel", y_reg, 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", y_reg, 4'b0000);
      @(posedge clk); #1;
      check("reset_hold", y_reg, 4'b0000);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release", y_reg, 4'b1000);

      // Disabled with unknown select: idle, never X.
      drive(1'b1, 1'bx, 1'bx);
      repeat (5) begin
         @(posedge clk); #1;
         check("dis_x_reg", y_reg, 4'b0000);
         check("dis_x_cmb", y_cmb, 4'b1111);
      end

      // Full truth table: registered one cycle late, combinational at once.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, i[1], i[0]);
         #1;
         check("tt_cmb", y_cmb, ~tt[i]);
         @(posedge clk); #1;
         check("tt_reg", y_reg, tt[i]);
      end

      // Enable toggle.
      drive(1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("en_on", y_reg, 4'b0100);
      #1;
      en = 1'b1;
      #1;
      check("en_off_cmb", y_cmb, 4'b1111);
      @(posedge clk); #1;
      check("en_off_reg", y_reg, 4'b0000);

      // Unknown select bit with enable active gives no line.
      drive(1'b0, 1'bx, 1'b0);
      exp = $isunknown(a) ? 4'b0000 : (a ? 4'b0100 : 4'b0001);
      @(posedge clk); #1;
      check("x_sel_reg", y_reg, exp);

      // Random run.
      for (int n = 0; n < 1000; n++) begin
         drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      cmp_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
